bcd_time_loader: RTL and testbench
==================================

Name: bcd_time_loader

Overview:
- Inverse of the stopwatch display path. Accepts a digit-serial BCD time entry in display order: minute tens, minute ones, second tens, second ones, centisecond tens, centisecond ones.
- Validates the six digits and converts them to binary minutes, seconds and centiseconds.
- Presents the binary values with a one-cycle load strobe that presets the stopwatch or timer counters.
- Sits between the button/keypad front end and the StopWatch counter block, in the mili_clk domain.

Parameters:
- BLANK_CODE, 10: digit code meaning blank; accepted and treated as 0.
- MAX_TENS, 5: highest legal tens digit for minutes and seconds.
- SET_MODE, 2'd2: currentMode value in which entry is enabled.

Ports:
- mili_clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- currentMode  in  2  active mode; entry is accepted only when equal to SET_MODE
- digit_valid  in  1  digit offered this cycle
- digit  in  4  BCD digit, 0-9 or BLANK_CODE
- digit_ready  out  1  loader can accept a digit
- commit  in  1  request load of a converted value
- cancel  in  1  abort entry and discard digits
- load  out  1  one-cycle strobe; the time outputs are valid while it is high
- minutes  out  6  binary minutes, 0-59
- seconds  out  6  binary seconds, 0-59
- centisec  out  7  binary centiseconds, 0-99
- entry_pos  out  3  index of the next digit expected, 0-5
- error  out  1  sticky invalid-entry flag

Behaviour:
- Reset (reset low, asynchronous):
  - state = ENTRY, entry_pos = 0, all six digit registers = 0.
  - load = 0, minutes = 0, seconds = 0, centisec = 0, error = 0.
- ENTRY:
  - digit_ready = 1 only when currentMode == SET_MODE.
  - A digit is accepted when digit_valid && digit_ready. It is stored at entry_pos, then entry_pos increments.
  - BLANK_CODE is stored as 0.
  - Codes 11-15 are rejected: error = 1, state -> ERROR, entry_pos is unchanged.
  - Accepting position 5 moves the state to CONVERT on the next cycle.
- CONVERT (exactly 1 cycle, digit_ready = 0):
  - Each field is computed as tens*10 + ones, with tens*10 formed as (tens<<3)+(tens<<1) in 7-bit arithmetic.
  - If minute tens > MAX_TENS or second tens > MAX_TENS: error = 1, state -> ERROR.
  - Otherwise the results are registered into hold registers and the state moves to WAIT.
- WAIT:
  - digit_ready = 0.
  - commit -> LOAD.
  - Outputs minutes/seconds/centisec hold their previous load values until LOAD.
- LOAD (1 cycle):
  - load = 1 and the outputs take the hold registers.
  - Next state: ENTRY, with entry_pos = 0 and digit registers cleared.
  - The outputs keep their values after LOAD.
- ERROR:
  - digit_ready = 0 and load is never asserted.
  - Exit only through cancel or reset.
- Cancel:
  - Has priority over every other event in any state.
  - Next cycle: ENTRY, entry_pos = 0, digits cleared, error = 0.
  - Cancel during LOAD still lets that cycle's strobe complete.
- Other boundary rules:
  - Leaving SET_MODE mid-entry freezes entry_pos and keeps the stored digits; entry resumes when the mode returns.
  - commit outside WAIT is ignored.
  - digit_valid while digit_ready = 0 is dropped, with no error.
  - Simultaneous digit_valid and commit in ENTRY: the digit is accepted and commit is ignored.
- Latency: last digit accepted at cycle N -> CONVERT at N+1 -> WAIT at N+2. The earliest load is at N+3 when commit is held.

Optional Feature:
- Macro BCD_LOADER_AUTOCOMMIT_EN.
- When defined, CONVERT goes directly to LOAD on success. load asserts at N+2, and commit is ignored.
- When undefined, the behaviour is as described above and WAIT requires commit.

Test Plan:
- Reset, mode = SET_MODE, digits 1,2,3,4,5,6, commit held -> load pulse 3 cycles after the last digit; minutes = 12, seconds = 34, centisec = 56; entry_pos returns to 0.
- Digits 10,7,10,0,9,9 (blanks), commit -> minutes = 7, seconds = 0, centisec = 99.
- Digits 6,0,0,0,0,0 -> error = 1 after CONVERT, no load; cancel -> error = 0, entry_pos = 0, digit_ready = 1.
- Digit 12 at position 2 -> error = 1, entry_pos stays 2; further digits are not accepted until cancel.
- Enter 3 digits, switch currentMode away (digit_ready = 0, pulses dropped), return, enter 3 more -> correct load; cancel asserted together with commit in WAIT -> no load, returns to ENTRY.
- With BCD_LOADER_AUTOCOMMIT_EN defined: digits 5,9,5,9,9,9, no commit -> load 2 cycles after the last digit; minutes = 59, seconds = 59, centisec = 99.

Source files
------------

// File: rtl/bcd_time_loader.sv
// Digit-serial BCD time entry (MM:SS:CC in display order) converted to binary with a load strobe.
// Optional macro BCD_LOADER_AUTOCOMMIT_EN: a successful conversion loads without waiting for commit.
module bcd_time_loader #(
    parameter int         BLANK_CODE = 10,
    parameter int         MAX_TENS   = 5,
    parameter logic [1:0] SET_MODE   = 2'd2
) (
    input  logic       mili_clk,
    input  logic       reset,
    input  logic [1:0] currentMode,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic       digit_ready,
    input  logic       commit,
    input  logic       cancel,
    output logic       load,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [6:0] centisec,
    output logic [2:0] entry_pos,
    output logic       error
);

    typedef enum logic [2:0] {
        S_ENTRY,
        S_CONVERT,
        S_WAIT,
        S_LOAD,
        S_ERROR
    } state_t;

    state_t          r_state;
    logic [2:0]      r_pos;
    logic [5:0][3:0] r_digits;
    logic            r_load;
    logic            r_error;
    logic [5:0]      r_min;
    logic [5:0]      r_sec;
    logic [6:0]      r_cs;

    logic       w_accept;
    logic       w_bad_code;
    logic       w_store;
    logic       w_clear;
    logic       w_tens_bad;
    logic [3:0] w_code;
    logic [6:0] w_min_bin;
    logic [6:0] w_sec_bin;
    logic [6:0] w_cs_bin;

    // tens*10 built from shifts so no multiplier is inferred
    function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] t7;
        t7 = {3'b000, tens};
        return (t7 << 3) + (t7 << 1) + {3'b000, ones};
    endfunction

    assign digit_ready = (r_state == S_ENTRY) && (currentMode == SET_MODE);
    assign w_accept    = digit_valid && digit_ready && !cancel;
    assign w_bad_code  = digit > 4'(BLANK_CODE);
    assign w_store     = w_accept && !w_bad_code;
    assign w_code      = (digit == 4'(BLANK_CODE)) ? 4'd0 : digit;
    assign w_clear     = cancel || (r_state == S_LOAD);

    assign w_min_bin  = bcd2bin(r_digits[0], r_digits[1]);
    assign w_sec_bin  = bcd2bin(r_digits[2], r_digits[3]);
    assign w_cs_bin   = bcd2bin(r_digits[4], r_digits[5]);
    assign w_tens_bad = (r_digits[0] > 4'(MAX_TENS)) || (r_digits[2] > 4'(MAX_TENS));

`ifdef BCD_LOADER_AUTOCOMMIT_EN
    logic [2:0] w_unused_bits;
    assign w_unused_bits = {w_min_bin[6], w_sec_bin[6], commit};
`else
    logic [1:0] w_unused_bits;
    logic [5:0] r_hold_min;
    logic [5:0] r_hold_sec;
    logic [6:0] r_hold_cs;
    assign w_unused_bits = {w_min_bin[6], w_sec_bin[6]};
`endif

    always_ff @(posedge mili_clk or negedge reset) begin
        if (!reset) begin
            r_digits <= '0;
        end else if (w_clear) begin
            r_digits <= '0;
        end else if (w_store) begin
            r_digits[r_pos] <= w_code;
        end
    end

    always_ff @(posedge mili_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_ENTRY;
            r_pos   <= 3'd0;
            r_load  <= 1'b0;
            r_error <= 1'b0;
            r_min   <= 6'd0;
            r_sec   <= 6'd0;
            r_cs    <= 7'd0;
`ifndef BCD_LOADER_AUTOCOMMIT_EN
            r_hold_min <= 6'd0;
            r_hold_sec <= 6'd0;
            r_hold_cs  <= 7'd0;
`endif
        end else if (cancel) begin
            // a strobe already high this cycle still completes; nothing new starts
            r_state <= S_ENTRY;
            r_pos   <= 3'd0;
            r_load  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_ENTRY: begin
                    r_load <= 1'b0;
                    if (w_accept) begin
                        if (w_bad_code) begin
                            r_error <= 1'b1;
                            r_state <= S_ERROR;
                        end else if (r_pos == 3'd5) begin
                            r_state <= S_CONVERT;
                        end else begin
                            r_pos <= r_pos + 3'd1;
                        end
                    end
                end
                S_CONVERT: begin
                    if (w_tens_bad) begin
                        r_error <= 1'b1;
                        r_state <= S_ERROR;
                    end else begin
`ifdef BCD_LOADER_AUTOCOMMIT_EN
                        r_min   <= w_min_bin[5:0];
                        r_sec   <= w_sec_bin[5:0];
                        r_cs    <= w_cs_bin;
                        r_load  <= 1'b1;
                        r_state <= S_LOAD;
`else
                        r_hold_min <= w_min_bin[5:0];
                        r_hold_sec <= w_sec_bin[5:0];
                        r_hold_cs  <= w_cs_bin;
                        r_state    <= S_WAIT;
`endif
                    end
                end
                S_WAIT: begin
`ifndef BCD_LOADER_AUTOCOMMIT_EN
                    if (commit) begin
                        r_min   <= r_hold_min;
                        r_sec   <= r_hold_sec;
                        r_cs    <= r_hold_cs;
                        r_load  <= 1'b1;
                        r_state <= S_LOAD;
                    end
`else
                    r_state <= S_ENTRY;
`endif
                end
                S_LOAD: begin
                    r_load  <= 1'b0;
                    r_pos   <= 3'd0;
                    r_state <= S_ENTRY;
                end
                S_ERROR: begin
                    r_load <= 1'b0;
                end
                default: begin
                    r_state <= S_ENTRY;
                    r_pos   <= 3'd0;
                    r_load  <= 1'b0;
                end
            endcase
        end
    end

    assign load      = r_load;
    assign minutes   = r_min;
    assign seconds   = r_sec;
    assign centisec  = r_cs;
    assign entry_pos = r_pos;
    assign error     = r_error;

endmodule

// File: tb/tb_bcd_time_loader.sv
// Randomized bench for bcd_time_loader against a transaction-level entry model.
// Honours BCD_LOADER_AUTOCOMMIT_EN in the same way as the design.
module tb_bcd_time_loader;

    logic       mili_clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] currentMode = 2'd2;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       digit_ready;
    logic       commit = 1'b0;
    logic       cancel = 1'b0;
    logic       load;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [6:0] centisec;
    logic [2:0] entry_pos;
    logic       error;

    int n_checks = 0;
    int n_errors = 0;
    int exp_min = 0;
    int exp_sec = 0;
    int exp_cs  = 0;

    bcd_time_loader dut (
        .mili_clk    (mili_clk),
        .reset       (reset),
        .currentMode (currentMode),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_ready (digit_ready),
        .commit      (commit),
        .cancel      (cancel),
        .load        (load),
        .minutes     (minutes),
        .seconds     (seconds),
        .centisec    (centisec),
        .entry_pos   (entry_pos),
        .error       (error)
    );

    always #5 mili_clk = ~mili_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mili_clk);
        #1;
    endtask

    function automatic int dval(input logic [3:0] x);
        return (x == 4'd10) ? 0 : int'(x);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_min"}, 32'(minutes), 32'(exp_min));
        check({tag, "_sec"}, 32'(seconds), 32'(exp_sec));
        check({tag, "_cs"}, 32'(centisec), 32'(exp_cs));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_pos"}, 32'(entry_pos), 32'd0);
        check({tag, "_err"}, 32'(error), 32'd0);
        check({tag, "_rdy"}, 32'(digit_ready), 32'd1);
    endtask

    task automatic do_cancel(input string tag);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        commit = 1'b0;
        check({tag, "_load"}, 32'(load), 32'd0);
        expect_idle(tag);
    endtask

    // One complete entry session; the model derives every expectation from the digit list.
    task automatic do_entry(input logic [5:0][3:0] dg, input bit mode_break,
                            input int commit_delay, input bit cancel_in_wait);
        int  mt, mo, st, so, ct, co;
        bit  bad_tens;
        logic [1:0] other_mode;
        for (int i = 0; i < 6; i++) begin
            if (mode_break && i == 3) begin
                other_mode  = 2'($urandom_range(0, 2));
                if (other_mode == 2'd2) other_mode = 2'd3;
                currentMode = other_mode;
                digit_valid = 1'b1;
                digit       = 4'($urandom_range(0, 15));
                #1;
                check("mode_off_rdy", 32'(digit_ready), 32'd0);
                tick();
                tick();
                check("mode_off_pos", 32'(entry_pos), 32'd3);
                check("mode_off_err", 32'(error), 32'd0);
                digit_valid = 1'b0;
                currentMode = 2'd2;
                #1;
            end
            check("pos", 32'(entry_pos), 32'(i));
            check("rdy", 32'(digit_ready), 32'd1);
            if (i == 5 && commit_delay == 0) commit = 1'b1;
            digit_valid = 1'b1;
            digit       = dg[i];
            tick();
            digit_valid = 1'b0;
            if (dg[i] > 4'd10) begin
                check("badcode_err", 32'(error), 32'd1);
                check("badcode_pos", 32'(entry_pos), 32'(i));
                check("badcode_rdy", 32'(digit_ready), 32'd0);
                digit_valid = 1'b1;
                digit       = 4'd3;
                commit      = 1'b1;
                tick();
                tick();
                digit_valid = 1'b0;
                check("errhold_pos", 32'(entry_pos), 32'(i));
                check("errhold_err", 32'(error), 32'd1);
                check("errhold_load", 32'(load), 32'd0);
                do_cancel("badcode_cancel");
                $display("entry digits=%h result=bad_code@%0d", dg, i);
                return;
            end
        end
        mt = dval(dg[0]); mo = dval(dg[1]);
        st = dval(dg[2]); so = dval(dg[3]);
        ct = dval(dg[4]); co = dval(dg[5]);
        bad_tens = (mt > 5) || (st > 5);
        check("convert_load", 32'(load), 32'd0);
        check("convert_rdy", 32'(digit_ready), 32'd0);
        tick();
        if (bad_tens) begin
            check("tens_err", 32'(error), 32'd1);
            check("tens_load", 32'(load), 32'd0);
            commit = 1'b1;
            tick();
            tick();
            check("tens_hold_load", 32'(load), 32'd0);
            check("tens_hold_err", 32'(error), 32'd1);
            check("tens_hold_rdy", 32'(digit_ready), 32'd0);
            do_cancel("tens_cancel");
            $display("entry digits=%h result=bad_tens", dg);
            return;
        end
`ifndef BCD_LOADER_AUTOCOMMIT_EN
        check("wait_load", 32'(load), 32'd0);
        check("wait_rdy", 32'(digit_ready), 32'd0);
        check_outputs("wait_prev");
        if (cancel_in_wait) begin
            commit = 1'b1;
            do_cancel("wait_cancel");
            check_outputs("wait_cancel_prev");
            $display("entry digits=%h result=cancelled", dg);
            return;
        end
        for (int k = 1; k < commit_delay; k++) begin
            tick();
            check("wait_nocommit_load", 32'(load), 32'd0);
        end
        commit = 1'b1;
        tick();
`else
        commit = 1'b0;
`endif
        commit  = 1'b0;
        exp_min = mt * 10 + mo;
        exp_sec = st * 10 + so;
        exp_cs  = ct * 10 + co;
        check("load_pulse", 32'(load), 32'd1);
        check_outputs("load");
        tick();
        check("after_load", 32'(load), 32'd0);
        check_outputs("after_load");
        expect_idle("after_load");
        $display("entry digits=%h result=load %0d:%0d.%0d", dg, exp_min, exp_sec, exp_cs);
    endtask

    function automatic logic [5:0][3:0] mk(input int a, input int b, input int c,
                                           input int d, input int e, input int f);
        logic [5:0][3:0] r;
        r[0] = 4'(a); r[1] = 4'(b); r[2] = 4'(c);
        r[3] = 4'(d); r[4] = 4'(e); r[5] = 4'(f);
        return r;
    endfunction

    function automatic logic [3:0] rand_digit(input int pos);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 4) return 4'($urandom_range(11, 15));
        if (r < 12) return 4'd10;
        if (pos == 0 || pos == 2) begin
            if (r < 18) return 4'($urandom_range(6, 9));
            return 4'($urandom_range(0, 5));
        end
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        logic [5:0][3:0] dg;
        reset = 1'b0;
        tick();
        tick();
        check("rst_load", 32'(load), 32'd0);
        check_outputs("rst");
        check("rst_pos", 32'(entry_pos), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        reset = 1'b1;
        tick();
        expect_idle("post_rst");

        do_entry(mk(1, 2, 3, 4, 5, 6), 1'b0, 0, 1'b0);
        do_entry(mk(10, 7, 10, 0, 9, 9), 1'b0, 2, 1'b0);
        do_entry(mk(6, 0, 0, 0, 0, 0), 1'b0, 0, 1'b0);
        do_entry(mk(1, 2, 12, 0, 0, 0), 1'b0, 0, 1'b0);
        do_entry(mk(4, 1, 2, 8, 3, 3), 1'b1, 1, 1'b0);
        do_entry(mk(2, 2, 2, 2, 2, 2), 1'b0, 0, 1'b1);
        do_entry(mk(5, 9, 5, 9, 9, 9), 1'b0, 0, 1'b0);

        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < 6; i++) dg[i] = rand_digit(i);
            do_entry(dg, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
